// File: rtl/sfq_xor_checker.sv
// sfq_xor_checker: checks a toggle-encoded SFQ XOR cell, one result per cell clock period
module sfq_xor_checker #(
    parameter int OUT_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a_t,
    input  logic             b_t,
    input  logic             ck_t,
    input  logic             out_t,
    output logic             res_valid,
    output logic [2:0]       res_code,
    output logic             res_expected,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             busy
);
    localparam int TW = $clog2(OUT_TIMEOUT + 1);
    localparam logic [2:0] C_OK = 3'd0, C_MISS = 3'd1, C_SPUR = 3'd2, C_MULTI = 3'd3, C_RACE = 3'd4;
    typedef enum logic {COLLECT, WAIT_OUT} state_t;
    state_t state_q, state_d;
    logic a_q, b_q, ck_q, out_q;
    logic a_seen_q, a_seen_d, b_seen_q, b_seen_d, multi_q, multi_d, spur_q, spur_d;
    logic p_exp_q, p_exp_d, p_multi_q, p_multi_d, p_race_q, p_race_d, p_spur_q, p_spur_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic res_valid_q, res_exp_q;
    logic [2:0] res_code_q, code;
    logic [CNT_W-1:0] err_q, per_q;
    logic a_ev, b_ev, ck_ev, out_ev, wait_st, decide, spur_now;
    assign a_ev     = en & (a_t ^ a_q);
    assign b_ev     = en & (b_t ^ b_q);
    assign ck_ev    = en & (ck_t ^ ck_q);
    assign out_ev   = en & (out_t ^ out_q);
    assign wait_st  = state_q == WAIT_OUT;
    // out pulses outside the window belong to the period being collected
    assign spur_now = spur_q | (out_ev & ~wait_st);
    assign decide   = wait_st & (out_ev | ck_ev | (en & tmr_q == TW'(1)));
    assign code     = p_race_q ? C_RACE : p_multi_q ? C_MULTI : p_spur_q ? C_SPUR :
                      out_ev ? (p_exp_q ? C_OK : C_SPUR) : (p_exp_q ? C_MISS : C_OK);
    always_comb begin
        state_d   = ck_ev ? WAIT_OUT : decide ? COLLECT : state_q;
        a_seen_d  = ck_ev ? a_ev : a_seen_q | a_ev;
        b_seen_d  = ck_ev ? b_ev : b_seen_q | b_ev;
        multi_d   = ck_ev ? 1'b0 : multi_q | (a_ev & a_seen_q) | (b_ev & b_seen_q);
        spur_d    = ck_ev ? 1'b0 : spur_now;
        p_exp_d   = ck_ev ? a_seen_q ^ b_seen_q : p_exp_q;
        p_multi_d = ck_ev ? multi_q : p_multi_q;
        p_race_d  = ck_ev ? a_ev | b_ev : p_race_q;
        p_spur_d  = ck_ev ? spur_now : p_spur_q;
        tmr_d     = ck_ev ? TW'(OUT_TIMEOUT) : (wait_st & en) ? tmr_q - 1'b1 : tmr_q;
    end
    always_ff @(posedge clk) begin
        a_q   <= a_t;
        b_q   <= b_t;
        ck_q  <= ck_t;
        out_q <= out_t;
        if (rst) begin
            state_q     <= COLLECT;
            a_seen_q    <= 1'b0;
            b_seen_q    <= 1'b0;
            multi_q     <= 1'b0;
            spur_q      <= 1'b0;
            p_exp_q     <= 1'b0;
            p_multi_q   <= 1'b0;
            p_race_q    <= 1'b0;
            p_spur_q    <= 1'b0;
            tmr_q       <= '0;
            res_valid_q <= 1'b0;
            res_code_q  <= C_OK;
            res_exp_q   <= 1'b0;
            err_q       <= '0;
            per_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_seen_q    <= a_seen_d;
            b_seen_q    <= b_seen_d;
            multi_q     <= multi_d;
            spur_q      <= spur_d;
            p_exp_q     <= p_exp_d;
            p_multi_q   <= p_multi_d;
            p_race_q    <= p_race_d;
            p_spur_q    <= p_spur_d;
            tmr_q       <= tmr_d;
            res_valid_q <= decide;
            if (decide) begin
                res_code_q <= code;
                res_exp_q  <= p_exp_q;
            end
            if (decide && per_q != '1)
                per_q <= per_q + 1'b1;
            if (decide && code != C_OK && err_q != '1)
                err_q <= err_q + 1'b1;
        end
    end
    assign res_valid    = res_valid_q;
    assign res_code     = res_code_q;
    assign res_expected = res_exp_q;
    assign err_cnt      = err_q;
    assign period_cnt   = per_q;
    assign busy         = wait_st;
endmodule

// File: tb/tb_sfq_xor_checker.sv
// tb_sfq_xor_checker: per-cycle vector table plus directed enable, reset and saturation sequences
module tb_sfq_xor_checker;
    logic clk = 1'b0, rst = 1'b1, en = 1'b1;
    logic a_t = 1'b0, b_t = 1'b0, ck_t = 1'b0, out_t = 1'b0;
    logic res_valid, res_expected, busy;
    logic [2:0] res_code;
    logic [15:0] err_cnt, period_cnt;
    int errors = 0, checks = 0;
    typedef struct {
        logic ta, tb, tc, to;
        logic vld;
        logic [2:0] code;
        logic ex, bsy;
        int pc, ec;
    } vec_t;
    vec_t vq[$];
    sfq_xor_checker #(.OUT_TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .a_t(a_t), .b_t(b_t), .ck_t(ck_t), .out_t(out_t),
        .res_valid(res_valid), .res_code(res_code), .res_expected(res_expected),
        .err_cnt(err_cnt), .period_cnt(period_cnt), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic add(input logic ta, tb, tc, to, vld, input logic [2:0] code,
                       input logic ex, bsy, input int pc, ec);
        vec_t v;
        v.ta = ta; v.tb = tb; v.tc = tc; v.to = to; v.vld = vld; v.code = code;
        v.ex = ex; v.bsy = bsy; v.pc = pc; v.ec = ec;
        vq.push_back(v);
    endtask
    task automatic idle(input int n, input logic bsy, input int pc, ec);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 3'd0, 0, bsy, pc, ec);
    endtask
    initial begin
        int nv;
        // basic OK period: a, ck 4 cycles later, out 3 cycles after ck
        add(1,0,0,0, 0,0,0,0, 0,0); idle(3,0,0,0); add(0,0,1,0, 0,0,0,1, 0,0);
        idle(2,1,0,0); add(0,0,0,1, 1,0,1,0, 1,0); idle(1,0,1,0);
        // a^b=0, no out: OK at timeout
        add(1,1,0,0, 0,0,0,0, 1,0); add(0,0,1,0, 0,0,0,1, 1,0); idle(7,1,1,0);
        add(0,0,0,0, 1,0,0,0, 2,0);
        // a^b=0 with out two cycles after ck: SPURIOUS
        add(1,1,0,0, 0,0,0,0, 2,0); add(0,0,1,0, 0,0,0,1, 2,0); idle(1,1,2,0);
        add(0,0,0,1, 1,2,0,0, 3,1); idle(1,0,3,1);
        // b only, no out: MISSING after exactly 8 busy cycles
        add(0,1,0,0, 0,0,0,0, 3,1); add(0,0,1,0, 0,0,0,1, 3,1); idle(7,1,3,1);
        add(0,0,0,0, 1,1,1,0, 4,2); idle(1,0,4,2);
        // a twice: MULTI
        add(1,0,0,0, 0,0,0,0, 4,2); add(1,0,0,0, 0,0,0,0, 4,2); add(0,0,1,0, 0,0,0,1, 4,2);
        add(0,0,0,1, 1,3,1,0, 5,3);
        // a with ck: RACE for closing period, a carried into the next
        add(1,0,1,0, 0,0,0,1, 5,3); idle(7,1,5,3); add(0,0,0,0, 1,4,0,0, 6,4);
        add(0,0,1,0, 0,0,0,1, 6,4); add(0,0,0,1, 1,0,1,0, 7,4);
        // ck inside the window closes the pending period and opens a new one
        add(0,1,0,0, 0,0,0,0, 7,4); add(0,0,1,0, 0,0,0,1, 7,4); add(1,0,0,0, 0,0,0,1, 7,4);
        add(0,0,1,0, 1,1,1,1, 8,5); add(0,0,0,1, 1,0,1,0, 9,5);
        // out coincident with ck counts against the closing period
        add(0,0,1,1, 0,0,0,1, 9,5); idle(7,1,9,5); add(0,0,0,0, 1,2,0,0, 10,6);
        step(); step();
        chk("reset_valid", res_valid, 0); chk("reset_code", res_code, 0);
        chk("reset_exp", res_expected, 0); chk("reset_err", err_cnt, 0);
        chk("reset_per", period_cnt, 0); chk("reset_busy", busy, 0);
        rst = 1'b0;
        step();
        for (int i = 0; i < vq.size(); i++) begin
            a_t ^= vq[i].ta; b_t ^= vq[i].tb; ck_t ^= vq[i].tc; out_t ^= vq[i].to;
            step();
            chk($sformatf("row%0d_valid", i), res_valid, vq[i].vld);
            chk($sformatf("row%0d_busy", i), busy, vq[i].bsy);
            chk($sformatf("row%0d_per", i), period_cnt, vq[i].pc);
            chk($sformatf("row%0d_err", i), err_cnt, vq[i].ec);
            if (vq[i].vld) begin
                chk($sformatf("row%0d_code", i), res_code, vq[i].code);
                chk($sformatf("row%0d_exp", i), res_expected, vq[i].ex);
            end
        end
        // en low freezes the window; events during it are lost
        b_t ^= 1'b1; step(); ck_t ^= 1'b1; step();
        chk("en_busy_start", busy, 1);
        en = 1'b0; nv = 0;
        out_t ^= 1'b1; a_t ^= 1'b1;
        for (int i = 0; i < 20; i++) begin step(); nv += int'(res_valid); end
        chk("en_off_novalid", nv, 0); chk("en_off_busy", busy, 1); chk("en_off_per", period_cnt, 10);
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin step(); nv += int'(res_valid); end
        chk("en_on_novalid", nv, 0); chk("en_on_busy", busy, 1);
        step();
        chk("en_valid", res_valid, 1); chk("en_code", res_code, 1); chk("en_exp", res_expected, 1);
        chk("en_per", period_cnt, 11); chk("en_err", err_cnt, 7);
        // reset inside the window discards the period
        a_t ^= 1'b1; step(); ck_t ^= 1'b1; step(); step();
        chk("rst_pre_busy", busy, 1);
        rst = 1'b1; step();
        chk("rst_valid", res_valid, 0); chk("rst_code", res_code, 0); chk("rst_exp", res_expected, 0);
        chk("rst_err", err_cnt, 0); chk("rst_per", period_cnt, 0); chk("rst_busy", busy, 0);
        rst = 1'b0; nv = 0;
        for (int i = 0; i < 12; i++) begin step(); nv += int'(res_valid); end
        chk("rst_after_novalid", nv, 0); chk("rst_after_busy", busy, 0);
        // one RACE result per cycle drives both counters into saturation
        for (int i = 0; i < 66000; i++) begin a_t ^= 1'b1; ck_t ^= 1'b1; step(); end
        for (int i = 0; i < 10; i++) step();
        chk("sat_per", period_cnt, 65535); chk("sat_err", err_cnt, 65535);
        chk("sat_code", res_code, 4); chk("sat_busy", busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
